xmoment_row_sequencer: RTL
==========================

Name: xmoment_row_sequencer

Overview:
- Sequences the x-moment datapath across one frame, one window-row at a time.
- Pulls column vectors from the column line buffer and drives the datapath's reset and advance strobes.
- After each row, inserts flush advances so the pipeline empties.
- Tags every valid moment result with its window-centre (x, y) coordinate for the downstream orientation stage.

Parameters:
IMAGE_WIDTH, 640, pixels per row
IMAGE_HEIGHT, 480, rows per frame
WINDOW_SIZE_X, 37, window width (odd)
WINDOW_SIZE_Y, 37, window height (odd)
PIPE_DELAY, 10, datapath advance latency (adder-tree stages + 4)

Derived:
- HALF_X = WINDOW_SIZE_X/2, HALF_Y = WINDOW_SIZE_Y/2
- FIRST_IDX = PIPE_DELAY+WINDOW_SIZE_X-1
- ADV_BITS = $clog2(IMAGE_WIDTH+PIPE_DELAY)
- X_BITS = $clog2(IMAGE_WIDTH), Y_BITS = $clog2(IMAGE_HEIGHT)

Ports:
clk  in  1  clock
in_reset_n  in  1  asynchronous active-low reset
in_frame_start  in  1  pulse; starts a frame (sampled only in IDLE)
in_row_ready  in  1  line buffer holds WINDOW_SIZE_Y rows for the current window-row
in_col_valid  in  1  column vector available from line buffer
out_col_ready  out  1  column consumed this cycle
in_stall  in  1  downstream hold; no advance while high
out_xm_valid  out  1  datapath advance strobe
out_xm_reset  out  1  datapath reset strobe
out_flush  out  1  column mux selects all-zero column
out_tag_valid  out  1  datapath output this cycle is a valid window result
out_center_x  out  X_BITS  window-centre x for tagged result
out_center_y  out  Y_BITS  window-centre y for tagged result
out_row_done  out  1  one-cycle pulse at end of each window-row
out_frame_done  out  1  one-cycle pulse after last window-row
out_busy  out  1  state != IDLE

Behaviour:
- Async reset:
  - state=IDLE, all counters 0.
  - All outputs 0, including out_center_x/y.
- States: IDLE, WAIT_ROW, STREAM, FLUSH, ROW_END.
- IDLE:
  - in_frame_start -> WAIT_ROW, row=0.
  - in_frame_start outside IDLE is ignored.
- WAIT_ROW: in_row_ready -> STREAM, adv_idx=0.
- STREAM:
  - Advance when in_col_valid && !in_stall.
  - On advance: out_xm_valid=1, out_col_ready=1, adv_idx++.
  - out_xm_reset=1 only on the advance with adv_idx==0; reset and valid are always paired.
  - After advance with adv_idx==IMAGE_WIDTH-1 -> FLUSH.
  - If PIPE_DELAY==0, go directly to ROW_END instead.
- FLUSH:
  - Advance when !in_stall: out_xm_valid=1, out_flush=1, out_col_ready=0.
  - After advance with adv_idx==IMAGE_WIDTH+PIPE_DELAY-1 -> ROW_END.
- ROW_END:
  - One cycle; out_row_done=1, row++.
  - If row was IMAGE_HEIGHT-WINDOW_SIZE_Y: out_frame_done=1 in the same cycle -> IDLE.
  - Otherwise -> WAIT_ROW.
- out_xm_valid, out_xm_reset, out_flush, out_col_ready:
  - Combinational from state and inputs, same cycle as the advance.
  - All are 0 in IDLE, WAIT_ROW and ROW_END.
- Tagging:
  - Registered: out_tag_valid is asserted in the cycle after an advance with FIRST_IDX <= adv_idx <= IMAGE_WIDTH+PIPE_DELAY-1.
  - out_center_x = adv_idx-FIRST_IDX+HALF_X.
  - out_center_y = row+HALF_Y.
  - Centre registers hold their value when out_tag_valid=0.
  - Exactly IMAGE_WIDTH-WINDOW_SIZE_X+1 tags per row.
  - Exactly IMAGE_HEIGHT-WINDOW_SIZE_Y+1 rows per frame.
- in_stall:
  - Freezes adv_idx and state; no advance, no tag in the next cycle.
  - Stall in STREAM overrides in_col_valid (out_col_ready=0).
- in_col_valid low in STREAM: bubble, same as a stall.
- in_row_ready is only sampled in WAIT_ROW.
- Reset mid-row: everything returns to IDLE immediately; no row_done or frame_done is emitted.

Test Plan:
1. Params W=8,H=5,WX=WY=3,PIPE_DELAY=4; frame_start, row_ready, col_valid held 1, stall 0 -> per row:
   - 12 xm_valid cycles (first with xm_reset), flush=1 on last 4.
   - Tags x=1..6 on 6 consecutive cycles starting the cycle after adv_idx 6.
   - row_done once; 3 rows with y=1,2,3; frame_done with third row_done.
2. Same config, in_col_valid toggled 1,0,1,0 during STREAM -> xm_valid/col_ready only on valid cycles; total 8 col_ready per row; tag x sequence unchanged.
3. in_stall high for 3 cycles in FLUSH at adv_idx 9 -> no xm_valid for 3 cycles, adv_idx held; tags resume with the next x, no duplicates or skips.
4. in_row_ready low for 5 cycles after row_done -> stays in WAIT_ROW, zero strobes, busy=1; proceeds on assertion.
5. in_frame_start pulsed during STREAM -> ignored; row count and frame_done timing identical to scenario 1.
6. in_reset_n asserted at adv_idx 5 of row 1 -> all outputs 0 asynchronously; after release, busy=0 until the next frame_start; the following frame matches scenario 1 exactly.

Source files
------------

// File: rtl/xmoment_row_sequencer.sv
// Row sequencer for the x-moment datapath: streams one window-row of columns,
// appends flush advances to drain the pipeline, and tags valid results with their window centre.
module xmoment_row_sequencer #(
    parameter int unsigned IMAGE_WIDTH   = 640,
    parameter int unsigned IMAGE_HEIGHT  = 480,
    parameter int unsigned WINDOW_SIZE_X = 37,
    parameter int unsigned WINDOW_SIZE_Y = 37,
    parameter int unsigned PIPE_DELAY    = 10,
    localparam int unsigned X_BITS = $clog2(IMAGE_WIDTH),
    localparam int unsigned Y_BITS = $clog2(IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              in_reset_n,
    input  logic              in_frame_start,
    input  logic              in_row_ready,
    input  logic              in_col_valid,
    output logic              out_col_ready,
    input  logic              in_stall,
    output logic              out_xm_valid,
    output logic              out_xm_reset,
    output logic              out_flush,
    output logic              out_tag_valid,
    output logic [X_BITS-1:0] out_center_x,
    output logic [Y_BITS-1:0] out_center_y,
    output logic              out_row_done,
    output logic              out_frame_done,
    output logic              out_busy
);

    localparam int unsigned HALF_X      = WINDOW_SIZE_X / 2;
    localparam int unsigned HALF_Y      = WINDOW_SIZE_Y / 2;
    localparam int unsigned FIRST_IDX   = PIPE_DELAY + WINDOW_SIZE_X - 1;
    localparam int unsigned ADV_BITS    = $clog2(IMAGE_WIDTH + PIPE_DELAY);
    localparam int unsigned LAST_STREAM = IMAGE_WIDTH - 1;
    localparam int unsigned LAST_ADV    = IMAGE_WIDTH + PIPE_DELAY - 1;
    localparam int unsigned LAST_ROW    = IMAGE_HEIGHT - WINDOW_SIZE_Y;
    // adv_idx - FIRST_IDX + HALF_X folded into one subtraction (never negative)
    localparam int unsigned X_OFFSET    = FIRST_IDX - HALF_X;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_STREAM,
        S_FLUSH,
        S_ROW_END
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADV_BITS-1:0]   adv_idx;
    logic [Y_BITS-1:0]     row;
    logic                  advance_c;
    logic                  last_row_c;
    logic                  tag_hit_c;

    assign last_row_c = (row == Y_BITS'(LAST_ROW));
    assign tag_hit_c  = advance_c && (adv_idx >= ADV_BITS'(FIRST_IDX))
                                  && (adv_idx <= ADV_BITS'(LAST_ADV));
    assign out_busy   = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt      = state;
        advance_c      = 1'b0;
        out_xm_valid   = 1'b0;
        out_xm_reset   = 1'b0;
        out_flush      = 1'b0;
        out_col_ready  = 1'b0;
        out_row_done   = 1'b0;
        out_frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_frame_start) state_nxt = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                if (in_row_ready) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (in_col_valid && !in_stall) begin
                    advance_c     = 1'b1;
                    out_xm_valid  = 1'b1;
                    out_col_ready = 1'b1;
                    out_xm_reset  = (adv_idx == '0);
                    if (adv_idx == ADV_BITS'(LAST_STREAM)) begin
                        state_nxt = (PIPE_DELAY == 0) ? S_ROW_END : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!in_stall) begin
                    advance_c    = 1'b1;
                    out_xm_valid = 1'b1;
                    out_flush    = 1'b1;
                    if (adv_idx == ADV_BITS'(LAST_ADV)) state_nxt = S_ROW_END;
                end
            end
            S_ROW_END: begin
                out_row_done = 1'b1;
                if (last_row_c) begin
                    out_frame_done = 1'b1;
                    state_nxt      = S_IDLE;
                end else begin
                    state_nxt = S_WAIT_ROW;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Advance index within the row and window-row counter
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            adv_idx <= '0;
            row     <= '0;
        end else begin
            if (state == S_IDLE && in_frame_start) row <= '0;
            if (state == S_WAIT_ROW && in_row_ready) adv_idx <= '0;
            if (advance_c) adv_idx <= adv_idx + ADV_BITS'(1);
            if (state == S_ROW_END) row <= row + Y_BITS'(1);
        end
    end

    // Result tag, one cycle behind the advance that produced it
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_tag_valid <= 1'b0;
            out_center_x  <= '0;
            out_center_y  <= '0;
        end else begin
            out_tag_valid <= tag_hit_c;
            if (tag_hit_c) begin
                out_center_x <= X_BITS'(adv_idx - ADV_BITS'(X_OFFSET));
                out_center_y <= row + Y_BITS'(HALF_Y);
            end
        end
    end

endmodule
